load_store_unit: RTL and testbench

- Memory-side initiator between the MIPS-16 execute stage and the byte-addressable, little-endian 64-byte data memory.
- Accepts one load or store at a time over a valid/ready handshake and drives the memory's we/addr/d_in.
- Captures the combinational d_out and returns sign- or zero-extended load data.
- Byte stores use read-modify-write, because the memory always writes two bytes (addr, addr+1). Illegal accesses are flagged and never reach the memory.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, access
// size codes and the default memory window limits.
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

    // First byte address outside the usable window.
    localparam logic [15:0] MEM_TOP_DEF  = 16'h003F;
    // First writable byte address; bytes below hold the read-only ID.
    localparam logic [15:0] WP_LIMIT_DEF = 16'h0005;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational data alignment for the load/store unit.
//   size_i     : access size (SZ_BYTE / SZ_HALF)
//   signed_i   : sign-extend byte loads
//   mem_dout_i : raw memory read data {byte addr+1, byte addr}
//   rdata_o    : extended load result
//   hi_i       : byte addr+1 captured during the read phase of a byte store
//   wdata_i    : store data (byte store uses [7:0])
//   din_o      : two-byte memory write word
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic        size_i,
    input  logic        signed_i,
    input  logic [15:0] mem_dout_i,
    output logic [15:0] rdata_o,
    input  logic [7:0]  hi_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] din_o
);

    always_comb begin
        rdata_o = mem_dout_i;
        if (size_i == SZ_BYTE) begin
            if (signed_i) rdata_o = {{8{mem_dout_i[7]}}, mem_dout_i[7:0]};
            else          rdata_o = {8'h00, mem_dout_i[7:0]};
        end
    end

    // The memory always writes two bytes, so a byte store re-writes the
    // neighbouring byte with the value read back just before.
    always_comb begin
        din_o = wdata_i;
        if (size_i == SZ_BYTE) din_o = {hi_i, wdata_i[7:0]};
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-side initiator between the execute stage and a byte-addressable,
// little-endian data memory with a combinational read port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (one outstanding request)
//   req_we/size/signed   : store flag, byte/halfword, sign-extend byte loads
//   req_addr/req_wdata   : byte address, store data
//   resp_valid/resp_err  : one-cycle completion pulse, rejected-access flag
//   resp_rdata           : load result, held until the next successful load
//   mem_we/addr/din      : memory write enable, byte address, write data
//   mem_dout             : memory read data {byte addr+1, byte addr}
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [15:0] MEM_TOP  = MEM_TOP_DEF,
    parameter logic [15:0] WP_LIMIT = WP_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_rdata,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    lsu_state_e  state_q, state_d;
    logic        accept;
    logic        acc_err;
    logic        err_q;
    logic        we_q, size_q, signed_q;
    logic [15:0] addr_q, wdata_q;
    logic [7:0]  hi_q;
    logic [15:0] rdata_q;
    logic [15:0] ld_data;
    logic [15:0] st_data;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign acc_err = (req_addr >= MEM_TOP) || (req_we && (req_addr < WP_LIMIT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_err)                 state_d = ST_RESP;
                    else if (!req_we)            state_d = ST_LOAD;
                    else if (req_size == SZ_HALF) state_d = ST_WRITE;
                    else                         state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept)              err_q   <= acc_err;
            if (state_q == ST_LOAD)  rdata_q <= ld_data;
        end
    end

    // Request payload and read-back byte; only meaningful while busy, so no
    // reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        if (state_q == ST_RMW_RD) hi_q <= mem_dout[15:8];
    end

    lsu_align u_align (
        .size_i     (size_q),
        .signed_i   (signed_q),
        .mem_dout_i (mem_dout),
        .rdata_o    (ld_data),
        .hi_i       (hi_q),
        .wdata_i    (wdata_q),
        .din_o      (st_data)
    );

    // Memory controls are decoded from the state alone, so an asynchronous
    // reset removes a pending write in the same instant.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_we     = (state_q == ST_WRITE) && we_q;
    assign mem_din    = (state_q == ST_WRITE) ? st_data : 16'h0000;
    assign mem_addr   = ((state_q == ST_LOAD) || (state_q == ST_RMW_RD) ||
                         (state_q == ST_WRITE)) ? addr_q : 16'h0000;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a 64-byte memory attached and a
// request-level reference model (byte array + expected response timing).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [15:0] MEM_TOP  = 16'h003F;
    localparam logic [15:0] WP_LIMIT = 16'h0005;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_size, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic        mem_we;
    logic [15:0] mem_addr, mem_din, mem_dout;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT.
    logic [7:0] phys [0:63];
    assign mem_dout = {phys[mem_addr[5:0] + 6'd1], phys[mem_addr[5:0]]};
    always @(posedge clk) begin
        if (mem_we) begin
            phys[mem_addr[5:0]]        <= mem_din[7:0];
            phys[mem_addr[5:0] + 6'd1] <= mem_din[15:8];
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [0:63];
    logic [15:0] model_rdata;
    int          cyc;
    int          exp_resp_cyc, exp_we_cyc;
    logic        exp_err;
    logic [15:0] exp_maddr, exp_din;
    int          nchecks, nerr;
    int          we_cnt;
    logic [15:0] last_din;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("resp_valid", {15'd0, resp_valid}, {15'd0, (cyc == exp_resp_cyc)});
            if (cyc == exp_resp_cyc) begin
                chk("resp_err", {15'd0, resp_err}, {15'd0, exp_err});
                chk("resp_rdata", resp_rdata, model_rdata);
            end
            chk("mem_we", {15'd0, mem_we}, {15'd0, (cyc == exp_we_cyc)});
            if (mem_we) begin
                we_cnt++;
                last_din = mem_din;
                chk("mem_addr_wr", mem_addr, exp_maddr);
                chk("mem_din_wr", mem_din, exp_din);
            end else begin
                chk("mem_din_idle", mem_din, 16'h0000);
            end
        end
    end

    task automatic do_req(input logic we, input logic sz, input logic sgn,
                          input logic [15:0] addr, input logic [15:0] wdata);
        logic       err;
        int         lat, a;
        logic [5:0] b0, b1;
        err = (addr >= MEM_TOP) || (we && (addr < WP_LIMIT));
        b0  = addr[5:0];
        b1  = b0 + 6'd1;
        if (err)     lat = 1;
        else if (!we) lat = 2;
        else if (sz) lat = 2;
        else         lat = 3;
        @(negedge clk);
        chk("req_ready_idle", {15'd0, req_ready}, 16'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        a = cyc + 1;
        @(posedge clk);
        exp_resp_cyc = a + lat - 1;
        exp_err      = err;
        if (!err && !we) begin
            if (sz)       model_rdata = {ref_mem[b1], ref_mem[b0]};
            else if (sgn) model_rdata = 16'($signed(ref_mem[b0]));
            else          model_rdata = 16'(ref_mem[b0]);
        end
        if (!err && we) begin
            exp_we_cyc = sz ? a : a + 1;
            exp_maddr  = addr;
            exp_din    = sz ? wdata : {ref_mem[b1], wdata[7:0]};
            ref_mem[b0] = exp_din[7:0];
            ref_mem[b1] = exp_din[15:8];
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (lat) @(negedge clk);
    endtask

    int wc0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; nchecks = 0; nerr = 0; we_cnt = 0; last_din = 16'h0;
        exp_resp_cyc = -1; exp_we_cyc = -1; exp_err = 1'b0;
        exp_maddr = 16'h0; exp_din = 16'h0; model_rdata = 16'h0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 16'h0; req_wdata = 16'h0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
        end
        ref_mem[0] = 8'h12; ref_mem[1] = 8'h02; ref_mem[2] = 8'h22;
        ref_mem[3] = 8'h20; ref_mem[4] = 8'h01;
        ref_mem[32] = 8'h5A; ref_mem[33] = 8'hC3;
        for (int i = 0; i < 64; i++) phys[i] = ref_mem[i];

        rst_n = 1'b0;
        #1;
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
        chk("rst_resp_err", {15'd0, resp_err}, 16'd0);
        chk("rst_rdata", resp_rdata, 16'h0000);
        chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_din", mem_din, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: ID halfword load
        do_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
        chk("t1_rdata_lit", resp_rdata, 16'h0212);

        // 2: halfword store then signed / unsigned byte loads
        wc0 = we_cnt;
        do_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'h8034);
        chk("t2_we_pulses", 16'(we_cnt - wc0), 16'd1);
        chk("t2_din_lit", last_din, 16'h8034);
        do_req(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0);
        chk("t2_sbyte_lit", resp_rdata, 16'hFF80);
        do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0);
        chk("t2_ubyte_lit", resp_rdata, 16'h0080);

        // 3: byte store via read-modify-write
        wc0 = we_cnt;
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h00AB);
        chk("t3_we_pulses", 16'(we_cnt - wc0), 16'd1);
        chk("t3_din_lit", last_din, 16'h80AB);
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t3_rdata_lit", resp_rdata, 16'h80AB);

        // 4: store into the read-only ID region is rejected
        wc0 = we_cnt;
        do_req(1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF);
        chk("t4_no_write", 16'(we_cnt - wc0), 16'd0);
        chk("t4_rdata_hold", resp_rdata, 16'h80AB);
        do_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
        chk("t4_rdata_lit", resp_rdata, 16'h0120);

        // 5: window top
        do_req(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0);
        chk("t5_rdata_hold", resp_rdata, 16'h0120);
        do_req(1'b1, 1'b1, 1'b0, 16'h003E, 16'h7788);
        chk("t5_din_lit", last_din, 16'h7788);
        do_req(1'b1, 1'b0, 1'b0, 16'h003E, 16'h0099);
        chk("t5_rmw_top_lit", last_din, 16'h7799);
        do_req(1'b0, 1'b1, 1'b0, 16'h003E, 16'h0);
        chk("t5_rdata_lit", resp_rdata, 16'h7799);
        do_req(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h1234);

        // 6: reset during RMW_RD of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0020; req_wdata = 16'h0011;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t6_in_rmw_addr", mem_addr, 16'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", {15'd0, req_ready}, 16'd1);
        chk("t6_rst_mem_we", {15'd0, mem_we}, 16'd0);
        chk("t6_rst_resp_valid", {15'd0, resp_valid}, 16'd0);
        chk("t6_rst_mem_addr", mem_addr, 16'h0000);
        exp_resp_cyc = -1;
        exp_we_cyc   = -1;
        model_rdata  = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rdata_cleared", resp_rdata, 16'h0000);
        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        chk("t6_orig_lit", resp_rdata, 16'hC35A);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
